// File: rtl/maze_writer.sv
// rtl/maze_writer.sv - queued cell/4x4-block writer into the maze framebuffer, writes only during vblank
// Optional 4x4 block fill enabled by defining MAZE_WRITER_FILL_EN.
module maze_writer #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [7:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [2:0]  cmd_code,
    input  logic        vblank,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic        busy,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [8:0]  X_LIM    = 9'(FB_W);
    localparam logic [7:0]  Y_LIM    = 8'(FB_H);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        PIX
`ifdef MAZE_WRITER_FILL_EN
        , FILL
`endif
    } state_t;

    state_t state, state_n;

    logic [7:0]  q_x    [FIFO_DEPTH];
    logic [6:0]  q_y    [FIFO_DEPTH];
    logic [2:0]  q_code [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, in_range, cmd_ok, accept, push, pop;

    logic [7:0]  cur_x, cur_x_n;
    logic [6:0]  cur_y, cur_y_n;
    logic [2:0]  cur_code, cur_code_n;
    logic        wr_en_n;
    logic [14:0] wr_addr_n;
    logic [2:0]  wr_data_n;
`ifdef MAZE_WRITER_FILL_EN
    logic        q_op [FIFO_DEPTH];
    logic        cur_op, cur_op_n;
    logic [3:0]  off, off_n;
    logic [7:0]  fill_x;
    logic [6:0]  fill_y;
`endif

    function automatic logic [14:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] y15;
        y15 = {8'd0, y};
        if (FB_W == 160)
            return (y15 << 7) + (y15 << 5) + {7'd0, x};
        else
            return 15'(FB_W) * y15 + {7'd0, x};
    endfunction

    assign empty     = (count == '0);
    assign cmd_ready = (count != FULL_CNT);
    assign busy      = !empty || (state != IDLE);
    assign in_range  = ({1'b0, cmd_x} < X_LIM) && ({1'b0, cmd_y} < Y_LIM);
`ifdef MAZE_WRITER_FILL_EN
    assign cmd_ok    = in_range;
    // Block base has its low two bits cleared, so the offset simply replaces them.
    assign fill_x    = {cur_x[7:2], off[1:0]};
    assign fill_y    = {cur_y[6:2], off[3:2]};
`else
    assign cmd_ok    = in_range && !cmd_op;
`endif
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && cmd_ok;

    always_ff @(posedge clk) begin
        if (push) begin
            q_x[wr_ptr]    <= cmd_x;
            q_y[wr_ptr]    <= cmd_y;
            q_code[wr_ptr] <= cmd_code;
`ifdef MAZE_WRITER_FILL_EN
            q_op[wr_ptr]   <= cmd_op;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
            if (accept && !cmd_ok && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cur_x    <= '0;
            cur_y    <= '0;
            cur_code <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef MAZE_WRITER_FILL_EN
            cur_op   <= 1'b0;
            off      <= '0;
`endif
        end else begin
            state    <= state_n;
            cur_x    <= cur_x_n;
            cur_y    <= cur_y_n;
            cur_code <= cur_code_n;
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
`ifdef MAZE_WRITER_FILL_EN
            cur_op   <= cur_op_n;
            off      <= off_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        cur_x_n    = cur_x;
        cur_y_n    = cur_y;
        cur_code_n = cur_code;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
`ifdef MAZE_WRITER_FILL_EN
        cur_op_n   = cur_op;
        off_n      = off;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    cur_x_n    = q_x[rd_ptr];
                    cur_y_n    = q_y[rd_ptr];
                    cur_code_n = q_code[rd_ptr];
`ifdef MAZE_WRITER_FILL_EN
                    cur_op_n   = q_op[rd_ptr];
                    off_n      = '0;
`endif
                    state_n    = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank) begin
`ifdef MAZE_WRITER_FILL_EN
                    state_n = cur_op ? FILL : PIX;
`else
                    state_n = PIX;
`endif
                end
            end
            PIX: begin
                // vblank may have dropped since WAIT_VB; hold off until it returns.
                if (vblank) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = cell_addr(cur_x, cur_y);
                    wr_data_n = cur_code;
                    state_n   = IDLE;
                end
            end
`ifdef MAZE_WRITER_FILL_EN
            FILL: begin
                if (vblank) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = cell_addr(fill_x, fill_y);
                    wr_data_n = cur_code;
                    off_n     = off + 4'd1;
                    if (off == 4'd15)
                        state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_maze_writer.sv
// tb/tb_maze_writer.sv - directed self-checking bench for maze_writer
module tb_maze_writer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [7:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [2:0]  cmd_code;
    logic        vblank;
    logic        wr_en, busy;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic [7:0]  drop_count;

    maze_writer #(.FB_W(160), .FB_H(120), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_code(cmd_code),
        .vblank(vblank),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_drop = 0;
    int wa[$];
    int wd[$];
    int wc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic op, input int x, input int y, input int code);
        int t;
        t = 0;
        cmd_op   = op;
        cmd_x    = 8'(x);
        cmd_y    = 7'(y);
        cmd_code = 3'(code);
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300)
            chk("send_ready_timeout", 32'(cmd_ready), 1);
        tick();
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (busy && t < 600) begin
            tick();
            t++;
        end
        chk("drain_busy", 32'(busy), 0);
        repeat (2) tick();
    endtask

    initial begin
        int base, acc, k, hi;
        bit r;
        reset = 1'b0; vblank = 1'b0; cmd_valid = 1'b0;
        cmd_op = 1'b0; cmd_x = '0; cmd_y = '0; cmd_code = '0;
        repeat (3) tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        reset = 1'b1;
        tick();

        // single write and latency
        vblank = 1'b1;
        base = wa.size();
        send(1'b0, 5, 2, 1);
        drain();
        chk("pix_count", 32'(wa.size() - base), 1);
        if (wa.size() > base) begin
            chk("pix_addr", 32'(wa[base]), 325);
            chk("pix_data", 32'(wd[base]), 1);
            chk("pix_latency", 32'(wc[base] - acc_cyc), 3);
        end

        // ordering, corner cells
        base = wa.size();
        send(1'b0, 0, 0, 3);
        send(1'b0, 159, 119, 7);
        send(1'b0, 10, 1, 2);
        drain();
        chk("ord_count", 32'(wa.size() - base), 3);
        if (wa.size() >= base + 3) begin
            chk("ord_addr0", 32'(wa[base]), 0);
            chk("ord_data0", 32'(wd[base]), 3);
            chk("ord_addr1", 32'(wa[base+1]), 19199);
            chk("ord_data1", 32'(wd[base+1]), 7);
            chk("ord_addr2", 32'(wa[base+2]), 170);
            chk("ord_data2", 32'(wd[base+2]), 2);
        end

`ifdef MAZE_WRITER_FILL_EN
        // full-speed fill
        base = wa.size();
        send(1'b1, 7, 9, 0);
        drain();
        chk("fill_count", 32'(wa.size() - base), 16);
        if (wa.size() >= base + 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("fill_addr%0d", i), 32'(wa[base+i]), 32'(1284 + (i / 4) * 160 + (i % 4)));
                chk($sformatf("fill_data%0d", i), 32'(wd[base+i]), 0);
                if (i > 0)
                    chk($sformatf("fill_gap%0d", i), 32'(wc[base+i] - wc[base+i-1]), 1);
            end
        end

        // fill paused by vblank after the 6th write
        base = wa.size();
        send(1'b1, 7, 9, 0);
        k = 0;
        for (int t = 0; t < 100 && k < 6; t++) begin
            tick();
            if (wr_en) k++;
        end
        vblank = 1'b0;
        hi = 0;
        repeat (20) begin
            tick();
            if (wr_en) hi++;
        end
        chk("pause_no_write", 32'(hi), 0);
        vblank = 1'b1;
        drain();
        chk("pause_count", 32'(wa.size() - base), 16);
        if (wa.size() >= base + 16) begin
            chk("pause_resume_addr", 32'(wa[base+6]), 1446);
            for (int i = 0; i < 16; i++)
                chk($sformatf("pause_addr%0d", i), 32'(wa[base+i]), 32'(1284 + (i / 4) * 160 + (i % 4)));
        end
`else
        // block fill disabled: op=1 is dropped
        base = wa.size();
        send(1'b1, 7, 9, 0);
        drain();
        exp_drop++;
        chk("op1_drop", 32'(drop_count), 32'(exp_drop));
        chk("op1_no_write", 32'(wa.size() - base), 0);
`endif

        // backpressure with vblank low
        vblank = 1'b0;
        base = wa.size();
        acc = 0;
        cmd_op = 1'b0; cmd_y = '0; cmd_code = 3'd4; cmd_x = 8'd0;
        cmd_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            r = cmd_ready;
            tick();
            if (r) begin
                acc++;
                cmd_x = 8'(acc);
            end
            chk("bp_busy", 32'(busy), 1);
        end
        chk("bp_accepted", 32'(acc), DEPTH + 1);
        chk("bp_ready_low", 32'(cmd_ready), 0);
        chk("bp_no_write", 32'(wa.size() - base), 0);
        vblank = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            tick();
            k++;
        end
        tick();
        cmd_valid = 1'b0;
        drain();
        chk("bp_count", 32'(wa.size() - base), DEPTH + 2);
        if (wa.size() >= base + DEPTH + 2)
            for (int i = 0; i < DEPTH + 2; i++)
                chk($sformatf("bp_addr%0d", i), 32'(wa[base+i]), 32'(i));

        // out-of-range drops and saturation
        base = wa.size();
        send(1'b0, 160, 0, 1);
        send(1'b0, 0, 120, 1);
        drain();
        exp_drop += 2;
        chk("oor_drop2", 32'(drop_count), 32'(exp_drop));
        chk("oor_no_write", 32'(wa.size() - base), 0);
        for (int i = 0; i < 300; i++)
            send(1'b0, (i % 2) ? 200 : 3, (i % 2) ? 5 : 127, 1);
        drain();
        chk("oor_saturate", 32'(drop_count), 255);
        chk("oor_no_write2", 32'(wa.size() - base), 0);

        // reset with queued commands
        vblank = 1'b0;
        base = wa.size();
        send(1'b0, 1, 1, 1);
        send(1'b0, 2, 1, 1);
        send(1'b0, 3, 1, 1);
        reset = 1'b0;
        #1;
        chk("qrst_ready", 32'(cmd_ready), 1);
        chk("qrst_busy", 32'(busy), 0);
        chk("qrst_drop", 32'(drop_count), 0);
        tick();
        reset = 1'b1;
        vblank = 1'b1;
        repeat (20) tick();
        chk("qrst_no_write", 32'(wa.size() - base), 0);

`ifdef MAZE_WRITER_FILL_EN
        // reset during the 4th fill write
        send(1'b0, 160, 0, 1);
        send(1'b1, 7, 9, 0);
        k = 0;
        for (int t = 0; t < 100 && k < 4; t++) begin
            tick();
            if (wr_en) k++;
        end
        reset = 1'b0;
        #1;
        chk("frst_wr_en", 32'(wr_en), 0);
        chk("frst_busy", 32'(busy), 0);
        chk("frst_ready", 32'(cmd_ready), 1);
        chk("frst_drop", 32'(drop_count), 0);
        tick();
        reset = 1'b1;
        hi = 0;
        repeat (30) begin
            tick();
            if (wr_en) hi++;
        end
        chk("frst_no_write", 32'(hi), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
